// File: rtl/wb_select_stage.sv
// Registered register-file writeback select: ALU, memory, SLT flag or link value, with load stall.
// Optional load sizing/alignment when WB_LOAD_EXT_EN is defined.
module wb_select_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        MD,
    input  logic [DATA_W-1:0] F,
    input  logic              N_xor_V,
    input  logic [DATA_W-1:0] link,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_we,
    input  logic [DATA_W-1:0] data_out,
    input  logic              mem_valid,
    input  logic              flush,
`ifdef WB_LOAD_EXT_EN
    input  logic [1:0]        ld_size,
    input  logic [0:0]        ld_signed,
    input  logic [1:0]        ld_off,
`endif
    output logic [DATA_W-1:0] Bus_D,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_we,
    output logic              busy
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] rd_p1;
    logic              we_p1;
    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] load_now;
    logic [DATA_W-1:0] load_pend;

`ifdef WB_LOAD_EXT_EN
    logic [1:0] size_p1;
    logic       signed_p1;
    logic [1:0] off_p1;

    // Halfwords ignore the low offset bit; word/reserved sizes keep the whole shifted word.
    function automatic logic [DATA_W-1:0] load_align(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        size,
        input logic              sgn,
        input logic [1:0]        off
    );
        logic [1:0]        eff_off;
        logic [DATA_W-1:0] sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        eff_off = (size == 2'd1) ? {off[1], 1'b0} : off;
        sh      = d >> {eff_off, 3'b000};
        b       = sh[7:0];
        h       = sh[15:0];
        case (size)
            2'd0:    load_align = sgn ? {{(DATA_W-8){b[7]}}, b}   : {{(DATA_W-8){1'b0}}, b};
            2'd1:    load_align = sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
            default: load_align = sh;
        endcase
    endfunction

    always_comb begin
        load_now  = load_align(data_out, ld_size, ld_signed[0], ld_off);
        load_pend = load_align(data_out, size_p1, signed_p1, off_p1);
    end
`else
    always_comb begin
        load_now  = data_out;
        load_pend = data_out;
    end
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_MEM);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        case (MD)
            2'd0:    sel_data = F;
            2'd1:    sel_data = load_now;
            2'd2:    sel_data = {{(DATA_W-1){1'b0}}, N_xor_V};
            default: sel_data = link;
        endcase
    end

    // Stage boundary: writeback registers and pending-load registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            Bus_D   <= '0;
            wb_addr <= '0;
            wb_we   <= 1'b0;
            rd_p1   <= '0;
            we_p1   <= 1'b0;
`ifdef WB_LOAD_EXT_EN
            size_p1   <= 2'd0;
            signed_p1 <= 1'b0;
            off_p1    <= 2'd0;
`endif
        end else begin
            wb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (MD != 2'd1 || mem_valid) begin
                            Bus_D   <= sel_data;
                            wb_addr <= rd;
                            wb_we   <= rd_we & (|rd);
                        end else begin
                            rd_p1 <= rd;
                            we_p1 <= rd_we;
`ifdef WB_LOAD_EXT_EN
                            size_p1   <= ld_size;
                            signed_p1 <= ld_signed[0];
                            off_p1    <= ld_off;
`endif
                            state <= WAIT_MEM;
                        end
                    end
                end
                default: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (mem_valid) begin
                        Bus_D   <= load_pend;
                        wb_addr <= rd_p1;
                        wb_we   <= we_p1 & (|rd_p1);
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Registered, parametrised successor to the combinational D-bus writeback mux.
- Selects the register-file write data from one of four sources:
  - ALU result F
  - memory read data data_out
  - set-less-than flag N_xor_V, zero-extended
  - link value PC+4
- Stalls on loads until memory data is valid, then presents a single-cycle register-file write: data, address and write enable.
- Sits between the execute/memory stage and the register file.

Parameters:
- DATA_W, 32, width of all data paths and Bus_D.
- ADDR_W, 5, register-file destination address width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream holds a valid writeback request.
- in_ready  output  1  stage can accept a request this cycle.
- MD  input  2  source select: 0=F, 1=data_out, 2=N_xor_V, 3=link.
- F  input  DATA_W  ALU result.
- N_xor_V  input  1  SLT flag.
- link  input  DATA_W  PC+4 for jump-and-link.
- rd  input  ADDR_W  destination register.
- rd_we  input  1  request writes the register file.
- data_out  input  DATA_W  memory read data.
- mem_valid  input  1  data_out valid this cycle (single-cycle pulse).
- flush  input  1  squash a pending request.
- Bus_D  output  DATA_W  registered writeback data.
- wb_addr  output  ADDR_W  registered destination.
- wb_we  output  1  register-file write strobe, one cycle per request.
- busy  output  1  high while in WAIT_MEM.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - Bus_D=0, wb_addr=0, wb_we=0, busy=0.
  - Any pending request is discarded.
- in_ready = (state==IDLE). Combinational from state only.
- Accept = in_valid & in_ready & ~flush.
- IDLE, accept with MD!=1 (latency 1):
  - Next edge: Bus_D = F, {DATA_W-1 zeros, N_xor_V}, or link, per MD.
  - wb_addr=rd, wb_we = rd_we & (rd!=0). State stays IDLE.
- IDLE, accept with MD==1 and mem_valid high in the same cycle:
  - Treated as zero-wait: Bus_D=data_out next edge, as above.
- IDLE, accept with MD==1 and mem_valid low:
  - Latch rd and rd_we into pending registers; go to WAIT_MEM; busy=1; wb_we=0.
- WAIT_MEM:
  - in_ready=0. in_valid is ignored.
  - On mem_valid: next edge Bus_D=data_out, wb_addr=pending rd, wb_we = pending we & (pending rd!=0); return to IDLE.
- wb_we is high for exactly one cycle per completed request and is 0 otherwise.
- Bus_D and wb_addr hold their last values when wb_we=0.
- Register 0 is never written: wb_we forced 0 for rd==0, but Bus_D still updates.
- flush:
  - In IDLE: blocks acceptance; outputs unchanged except wb_we=0.
  - In WAIT_MEM: return to IDLE, no write.
  - flush together with mem_valid: flush wins, no write.
- mem_valid in IDLE with no load accepted: ignored.
- Width: N_xor_V is zero-extended to DATA_W. No other truncation or extension, except under the optional feature.

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined:
  - Adds inputs ld_size[1:0] (0=byte, 1=half, 2=word) and ld_signed[0:0], plus ld_off[1:0] (byte offset).
  - These are latched with the request alongside rd.
  - Memory data is shifted right by 8*ld_off, masked to the size, then sign- or zero-extended per ld_signed before reaching Bus_D.
  - For the half case, ld_off[0] is ignored.
- Undefined:
  - These ports do not exist.
  - data_out passes through unmodified as a full word.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT_MEM → immediately Bus_D=0, wb_we=0, busy=0, in_ready=1. No write after release.
- ALU path: MD=0, F=32'h1234_5678, rd=3, rd_we=1 → next cycle Bus_D=32'h1234_5678, wb_addr=3, wb_we=1 for one cycle.
- SLT path and r0:
  - MD=2, N_xor_V=1, rd=7 → Bus_D=32'h0000_0001, wb_we=1.
  - Repeat with rd=0 → Bus_D=1, wb_we=0.
- Load with wait:
  - MD=1, rd=9, mem_valid low 3 cycles: busy=1 and in_ready=0 throughout.
  - Then mem_valid=1, data_out=32'hDEAD_BEEF → next cycle Bus_D=32'hDEAD_BEEF, wb_addr=9, wb_we=1.
- Zero-wait load: MD=1 with mem_valid=1, data_out=32'hCAFE_0001 in the same cycle → no busy, write after 1 cycle.
- Flush: enter WAIT_MEM, then flush=1 with mem_valid=1 → no wb_we, state IDLE. With WB_LOAD_EXT_EN: byte signed, ld_off=2, data_out=32'h0080_0000 → Bus_D=32'hFFFF_FF80.
